// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
// The state type is only used when REGFILE_INIT_SWEEP_EN is defined.
package regfile_pkg;

   localparam int unsigned DefXlen     = 32;
   localparam int unsigned DefRegCount = 32;

   typedef enum logic {
      StInit,
      StReady
   } state_e;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write bus of the register file; master is decode/writeback, slave is the file.
interface regfile_mp_if #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned ADDR_W     = 5
);
   logic                         ready;
   logic                         rs_stall;
   logic [READ_PORTS-1:0]        rs_enable;
   logic [READ_PORTS*ADDR_W-1:0] rs_sel;
   logic [READ_PORTS*XLEN-1:0]   rs_out;
   logic                         rd_enable;
   logic [ADDR_W-1:0]            rd_sel;
   logic [XLEN-1:0]              rd_data;

   modport master (
      input  ready, rs_out,
      output rs_stall, rs_enable, rs_sel, rd_enable, rd_sel, rd_data
   );

   modport slave (
      output ready, rs_out,
      input  rs_stall, rs_enable, rs_sel, rd_enable, rd_sel, rd_data
   );
endinterface

// File: rtl/regfile_read_port.sv
// One registered read port: select, write bypass, stall hold and zero forcing.
module regfile_read_port #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned REG_COUNT = 32,
   parameter int unsigned ZERO_REG  = 1
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_active,
   input  logic              i_stall,
   input  logic              i_enable,
   input  logic [ADDR_W-1:0] i_sel,
   input  logic [XLEN-1:0]   i_rdata,
   input  logic              i_wr_en,
   input  logic [ADDR_W-1:0] i_wr_sel,
   input  logic [XLEN-1:0]   i_wr_data,
   output logic [XLEN-1:0]   o_data
);
   localparam logic [ADDR_W:0] RegLimit = (ADDR_W+1)'(REG_COUNT);

   logic [XLEN-1:0] r_data;
   logic [XLEN-1:0] w_next;
   logic            w_blank;

   assign w_blank = !i_enable || ({1'b0, i_sel} >= RegLimit) ||
                    ((ZERO_REG != 0) && (i_sel == '0));

   always_comb begin
      w_next = i_rdata;
      if (w_blank) begin
         w_next = '0;
      end else if (i_wr_en && (i_wr_sel == i_sel)) begin
         w_next = i_wr_data;
      end
   end

   // Until the file is active the output is forced to zero and stall is ignored.
   always_ff @(posedge i_clk) begin
      if (i_reset || !i_active) begin
         r_data <= '0;
      end else if (!i_stall) begin
         r_data <= w_next;
      end
   end

   assign o_data = r_data;
endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with one bypassed write port.
// Define REGFILE_INIT_SWEEP_EN to zero every register after reset before ready rises.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned XLEN       = DefXlen,
   parameter int unsigned REG_COUNT  = DefRegCount,
   parameter int unsigned READ_PORTS = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic         clk,
   input  logic         reset,
   regfile_mp_if.slave  bus
);
   localparam int unsigned     ADDR_W   = clog2(REG_COUNT);
   localparam logic [ADDR_W:0] RegLimit = (ADDR_W+1)'(REG_COUNT);

   logic [XLEN-1:0]   r_regs [REG_COUNT];
   logic              r_ready;
   logic              w_wr_qual;
   logic              w_st_en;
   logic [ADDR_W-1:0] w_st_idx;
   logic [XLEN-1:0]   w_st_data;

   assign w_wr_qual = bus.rd_enable && r_ready && !reset &&
                      ({1'b0, bus.rd_sel} < RegLimit) &&
                      !((ZERO_REG != 0) && (bus.rd_sel == '0));

`ifdef REGFILE_INIT_SWEEP_EN
   state_e            r_state;
   logic [ADDR_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= StInit;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else if (r_state == StInit) begin
         r_cnt <= r_cnt + 1'b1;
         if (r_cnt == ADDR_W'(REG_COUNT - 1)) begin
            r_state <= StReady;
            r_ready <= 1'b1;
         end
      end
   end

   always_comb begin
      w_st_en   = w_wr_qual;
      w_st_idx  = bus.rd_sel;
      w_st_data = bus.rd_data;
      if ((r_state == StInit) && !reset) begin
         w_st_en   = 1'b1;
         w_st_idx  = r_cnt;
         w_st_data = '0;
      end
   end
`else
   always_ff @(posedge clk) begin
      r_ready <= !reset;
   end

   assign w_st_en   = w_wr_qual;
   assign w_st_idx  = bus.rd_sel;
   assign w_st_data = bus.rd_data;
`endif

   always_ff @(posedge clk) begin
      if (w_st_en) begin
         r_regs[w_st_idx] <= w_st_data;
      end
   end

   assign bus.ready = r_ready;

   for (genvar g = 0; g < READ_PORTS; g++) begin : g_port
      logic [ADDR_W-1:0] w_sel;
      assign w_sel = bus.rs_sel[g*ADDR_W +: ADDR_W];

      regfile_read_port #(
         .XLEN      (XLEN),
         .ADDR_W    (ADDR_W),
         .REG_COUNT (REG_COUNT),
         .ZERO_REG  (ZERO_REG)
      ) u_port (
         .i_clk     (clk),
         .i_reset   (reset),
         .i_active  (r_ready),
         .i_stall   (bus.rs_stall),
         .i_enable  (bus.rs_enable[g]),
         .i_sel     (w_sel),
         .i_rdata   (r_regs[w_sel]),
         .i_wr_en   (w_wr_qual),
         .i_wr_sel  (bus.rd_sel),
         .i_wr_data (bus.rd_data),
         .o_data    (bus.rs_out[g*XLEN +: XLEN])
      );
   end
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32-entry ZERO_REG=1 instance and a 20-entry ZERO_REG=0 one.
// Sweep timing checks apply when REGFILE_INIT_SWEEP_EN is defined.
module tb_regfile_mp;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   regfile_mp_if #(.XLEN(32), .READ_PORTS(2), .ADDR_W(5)) bus0 ();
   regfile_mp_if #(.XLEN(32), .READ_PORTS(1), .ADDR_W(5)) bus1 ();

   regfile_mp #(.XLEN(32), .REG_COUNT(32), .READ_PORTS(2), .ZERO_REG(1)) u_dut0 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus0)
   );

   regfile_mp #(.XLEN(32), .REG_COUNT(20), .READ_PORTS(1), .ZERO_REG(0)) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   typedef struct {
      string       tag;
      int          dut;
      int          port;   // -1 selects the ready flag
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic void push(input string tag, input int dut, input int port,
                                input logic [31:0] v);
      exp_t e;
      e.tag  = tag;
      e.dut  = dut;
      e.port = port;
      e.exp  = v;
      sb.push_back(e);
   endfunction

   function automatic logic [31:0] observe(input int dut, input int port);
      if (dut == 0) begin
         if (port < 0) return {31'b0, bus0.ready};
         return bus0.rs_out[port*32 +: 32];
      end
      if (port < 0) return {31'b0, bus1.ready};
      return bus1.rs_out[31:0];
   endfunction

   task automatic cycle();
      exp_t        e;
      logic [31:0] o;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         o = observe(e.dut, e.port);
         checks++;
         assert (o === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic idle();
      bus0.rs_stall  = 1'b0;
      bus0.rs_enable = '0;
      bus0.rs_sel    = '0;
      bus0.rd_enable = 1'b0;
      bus0.rd_sel    = '0;
      bus0.rd_data   = '0;
      bus1.rs_stall  = 1'b0;
      bus1.rs_enable = '0;
      bus1.rs_sel    = '0;
      bus1.rd_enable = 1'b0;
      bus1.rd_sel    = '0;
      bus1.rd_data   = '0;
   endtask

   task automatic rd0(input int p, input int sel);
      bus0.rs_enable[p]       = 1'b1;
      bus0.rs_sel[p*5 +: 5]   = 5'(sel);
   endtask

   task automatic wr0(input int sel, input logic [31:0] d);
      bus0.rd_enable = 1'b1;
      bus0.rd_sel    = 5'(sel);
      bus0.rd_data   = d;
   endtask

   task automatic rd1(input int sel);
      bus1.rs_enable = 1'b1;
      bus1.rs_sel    = 5'(sel);
   endtask

   task automatic wr1(input int sel, input logic [31:0] d);
      bus1.rd_enable = 1'b1;
      bus1.rd_sel    = 5'(sel);
      bus1.rd_data   = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      idle();
      for (int i = 0; i < 2; i++) begin
         push("reset_out0", 0, 0, 32'h0);
         push("reset_out1", 0, 1, 32'h0);
         push("reset_ready0", 0, -1, 32'h0);
         push("reset_ready1", 1, -1, 32'h0);
         push("reset_out_d1", 1, 0, 32'h0);
         cycle();
      end
      reset = 1'b0;

`ifdef REGFILE_INIT_SWEEP_EN
      // Writes during INIT must be dropped and outputs forced to zero.
      for (int k = 1; k <= 32; k++) begin
         idle();
         wr0(3, 32'h55);
         rd0(0, 3);
         if (k <= 20) wr1(3, 32'h55);
         rd1(3);
         push("sweep_ready0", 0, -1, (k == 32) ? 32'h1 : 32'h0);
         push("sweep_out0", 0, 0, 32'h0);
         push("sweep_ready1", 1, -1, (k >= 20) ? 32'h1 : 32'h0);
         push("sweep_out_d1", 1, 0, 32'h0);
         cycle();
      end
      for (int idx = 1; idx < 32; idx++) begin
         idle();
         rd0(0, idx);
         rd0(1, 32 - idx);
         push("sweep_zero_p0", 0, 0, 32'h0);
         push("sweep_zero_p1", 0, 1, 32'h0);
         cycle();
      end
`else
      idle();
      push("ready0_after_reset", 0, -1, 32'h1);
      push("ready1_after_reset", 1, -1, 32'h1);
      cycle();
`endif

      // Write then read
      idle();
      wr0(5, 32'hDEADBEEF);
      push("wr_no_enable_out0", 0, 0, 32'h0);
      cycle();
      idle();
      rd0(0, 5);
      push("read_x5", 0, 0, 32'hDEADBEEF);
      cycle();

      // Bypass to both ports, then committed value
      idle();
      wr0(7, 32'h1234);
      rd0(0, 7);
      rd0(1, 7);
      push("bypass_p0", 0, 0, 32'h1234);
      push("bypass_p1", 0, 1, 32'h1234);
      cycle();
      idle();
      rd0(0, 7);
      rd0(1, 5);
      bus0.rs_enable[1] = 1'b0;
      push("committed_x7", 0, 0, 32'h1234);
      push("disabled_p1", 0, 1, 32'h0);
      cycle();

      // Zero register: hardwired on dut0, ordinary on dut1
      idle();
      wr0(0, 32'hFFFFFFFF);
      rd0(0, 0);
      rd0(1, 0);
      wr1(0, 32'hFFFFFFFF);
      rd1(0);
      push("x0_bypass_zero_p0", 0, 0, 32'h0);
      push("x0_bypass_zero_p1", 0, 1, 32'h0);
      push("x0_bypass_d1", 1, 0, 32'hFFFFFFFF);
      cycle();
      idle();
      rd0(0, 0);
      rd1(0);
      push("x0_read_zero", 0, 0, 32'h0);
      push("x0_read_d1", 1, 0, 32'hFFFFFFFF);
      cycle();

      // Out-of-range indices on the 20-entry instance
      idle();
      wr1(25, 32'h77);
      rd1(25);
      push("oor_bypass_d1", 1, 0, 32'h0);
      cycle();
      idle();
      wr1(19, 32'hCAFE);
      rd1(19);
      push("last_bypass_d1", 1, 0, 32'hCAFE);
      cycle();
      idle();
      rd1(20);
      push("oor_read_d1", 1, 0, 32'h0);
      cycle();
      idle();
      rd1(19);
      push("last_read_d1", 1, 0, 32'hCAFE);
      cycle();

      // Stall: held outputs ignore writes, release shows the new value
      idle();
      wr0(9, 32'hAA);
      rd0(0, 5);
      push("pre_stall_p0", 0, 0, 32'hDEADBEEF);
      cycle();
      idle();
      rd0(0, 5);
      rd0(1, 9);
      push("pre_stall_p1", 0, 1, 32'hAA);
      cycle();
      for (int i = 0; i < 3; i++) begin
         idle();
         bus0.rs_stall = 1'b1;
         wr0(9, 32'hBB);
         rd0(0, 7);
         rd0(1, 9);
         push("stall_hold_p0", 0, 0, 32'hDEADBEEF);
         push("stall_hold_p1", 0, 1, 32'hAA);
         cycle();
      end
      idle();
      rd0(0, 7);
      rd0(1, 9);
      push("unstall_p0", 0, 0, 32'h1234);
      push("unstall_p1", 0, 1, 32'hBB);
      cycle();

      // Reset in operation
      idle();
      reset = 1'b1;
      rd0(0, 5);
      rd0(1, 9);
      push("opreset_out0", 0, 0, 32'h0);
      push("opreset_out1", 0, 1, 32'h0);
      push("opreset_ready", 0, -1, 32'h0);
      cycle();
      reset = 1'b0;

`ifdef REGFILE_INIT_SWEEP_EN
      for (int k = 1; k <= 10; k++) begin
         idle();
         push("sweep1_ready", 0, -1, 32'h0);
         cycle();
      end
      reset = 1'b1;
      push("midsweep_reset_ready", 0, -1, 32'h0);
      cycle();
      reset = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         idle();
         push("sweep2_ready", 0, -1, (k == 32) ? 32'h1 : 32'h0);
         cycle();
      end
      idle();
      rd0(0, 5);
      rd0(1, 9);
      push("resweep_x5", 0, 0, 32'h0);
      push("resweep_x9", 0, 1, 32'h0);
      cycle();
`else
      idle();
      push("opreset_ready_back", 0, -1, 32'h1);
      cycle();
      idle();
      rd0(0, 5);
      rd0(1, 9);
      push("retained_x5", 0, 0, 32'hDEADBEEF);
      push("retained_x9", 0, 1, 32'hBB);
      cycle();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
